logic_unit_arbiter: RTL and testbench

Shares one registered 64-bit logical unit (AND/OR/XOR/NOT) between two requesters in the ALU.
- Round-robin arbitration.
- Valid/ready handshake on every request and on the single shared result port.
- One-cycle latency; full throughput under backpressure.
- Results are tagged with the requester ID so downstream ALU steering can route them.

---
 rtl/logic_unit_arbiter.sv | 93 +++++++++
 tb/tb_logic_unit_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Purpose : round-robin share of one registered bitwise logic unit (AND/OR/XOR/NOT) between two requesters.
// Latency : one cycle; a request accepted at edge k is presented on res_* after edge k.
// Backpres: readies follow res_ready combinationally; a full, stalled result register blocks both requesters.
//
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   rN_valid/rN_ready          request handshake for requester N (0 or 1)
//   rN_op, rN_a, rN_b          opcode (00 and, 01 or, 10 xor, 11 not-a) and operands
//   res_valid/res_ready        result handshake
//   res_id, res_op, res_data   issuing requester, opcode and value of the held result
module logic_unit_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [1:0]       r0_op,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [1:0]       r1_op,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [1:0]       res_op,
  output logic [WIDTH-1:0] res_data
);

  // Requester granted by the most recent accepted transfer. Resets to 1 so
  // that requester 0 wins the first contention.
  logic             last_grant;

  logic             can_accept;
  logic             grant_vld;
  logic             grant_id;
  logic             xfer;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] op_result;

  // Arbitration and handshake. The result register can take a new value when
  // it is empty or is being drained in the same cycle (flow-through).
  always_comb begin
    can_accept = !res_valid || res_ready;
    grant_vld  = r0_valid || r1_valid;
    // Both valid: alternate away from the last winner; otherwise the sole
    // valid requester wins (r1_valid alone selects 1, r0_valid alone 0).
    grant_id   = (r0_valid && r1_valid) ? ~last_grant : r1_valid;
    r0_ready   = can_accept && grant_vld && !grant_id && rst_n;
    r1_ready   = can_accept && grant_vld &&  grant_id && rst_n;
    xfer       = (r0_valid && r0_ready) || (r1_valid && r1_ready);
  end

  // Operand steering and the shared bitwise unit.
  always_comb begin
    sel_op    = grant_id ? r1_op : r0_op;
    sel_a     = grant_id ? r1_a  : r0_a;
    sel_b     = grant_id ? r1_b  : r0_b;
    op_result = '0;
    case (sel_op)
      2'b00:   op_result = sel_a & sel_b;
      2'b01:   op_result = sel_a | sel_b;
      2'b10:   op_result = sel_a ^ sel_b;
      default: op_result = ~sel_a;
    endcase
  end

  // Result register. Payload fields only change on a transfer so a drained
  // result keeps its last value visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_id     <= 1'b0;
      res_op     <= 2'b00;
      last_grant <= 1'b1;
    end else if (xfer) begin
      res_valid  <= 1'b1;
      res_data   <= op_result;
      res_id     <= grant_id;
      res_op     <= sel_op;
      last_grant <= grant_id;
    end else if (res_ready) begin
      res_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Purpose : directed self-checking bench for logic_unit_arbiter.
// Latency : inputs driven 1ns after a rising edge, registered outputs checked there too.
// Backpres: res_ready driven directly by the bench to exercise stall and drain.
module tb_logic_unit_arbiter;

  localparam int W = 64;

  localparam logic [W-1:0] P_AA   = {16{4'hA}};
  localparam logic [W-1:0] P_55   = {16{4'h5}};
  localparam logic [W-1:0] P_ONES = {W{1'b1}};
  localparam logic [W-1:0] P_F0   = {8{8'hF0}};
  localparam logic [W-1:0] P_FF00 = {4{16'hFF00}};
  localparam logic [W-1:0] P_AND  = {4{16'hF000}};
  localparam logic [W-1:0] P_OR   = {4{16'hFFF0}};
  localparam logic [W-1:0] P_NA   = 64'h0123456789ABCDEF;
  localparam logic [W-1:0] P_NOT  = 64'hFEDCBA9876543210;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         r0_valid, r1_valid;
  logic         r0_ready, r1_ready;
  logic [1:0]   r0_op, r1_op;
  logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
  logic         res_valid, res_ready, res_id;
  logic [1:0]   res_op;
  logic [W-1:0] res_data;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_data;
  logic         exp_id;

  logic_unit_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r0_valid  (r0_valid),
    .r0_ready  (r0_ready),
    .r0_op     (r0_op),
    .r0_a      (r0_a),
    .r0_b      (r0_b),
    .r1_valid  (r1_valid),
    .r1_ready  (r1_ready),
    .r1_op     (r1_op),
    .r1_a      (r1_a),
    .r1_b      (r1_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_op    (res_op),
    .res_data  (res_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    r0_valid  = 1'b1;  r0_op = 2'b10; r0_a = P_AA; r0_b = P_55;
    r1_valid  = 1'b0;  r1_op = 2'b00; r1_a = '0;   r1_b = '0;
    res_ready = 1'b1;

    // Reset held two cycles with r0 requesting.
    tick();
    tick();
    check("rst_r0_ready",  r0_ready,  0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data",  res_data,  0);
    check("rst_res_id",    res_id,    0);

    // Release; r0 is ready immediately with an XOR pending.
    rst_n = 1'b1;
    #1;
    check("rel_r0_ready", r0_ready, 1);
    check("rel_r1_ready", r1_ready, 0);
    tick();
    check("xor1_valid", res_valid, 1);
    check("xor1_id",    res_id,    0);
    check("xor1_op",    res_op,    2'b10);
    check("xor1_data",  res_data,  P_ONES);

    // Back-to-back XOR of equal operands while draining.
    r0_b = P_AA;
    #1;
    check("xor2_ready", r0_ready, 1);
    tick();
    check("xor2_valid", res_valid, 1);
    check("xor2_data",  res_data,  0);

    // Drain with no request: valid drops, payload holds.
    r0_valid = 1'b0;
    tick();
    check("drain_valid", res_valid, 0);
    check("drain_data",  res_data,  0);
    check("drain_op",    res_op,    2'b10);

    // Short reset so contention starts from requester-0 priority.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Contention: ids alternate 0,1,0,1, one result per cycle.
    r0_valid = 1'b1; r0_op = 2'b00; r0_a = P_F0; r0_b = P_FF00;
    r1_valid = 1'b1; r1_op = 2'b01; r1_a = P_F0; r1_b = P_FF00;
    for (int i = 0; i < 4; i++) begin
      exp_id   = i[0];
      exp_data = exp_id ? P_OR : P_AND;
      #1;
      check("rr_r0_ready", r0_ready, !exp_id);
      check("rr_r1_ready", r1_ready, exp_id);
      tick();
      check("rr_valid", res_valid, 1);
      check("rr_id",    res_id,    exp_id);
      check("rr_data",  res_data,  exp_data);
    end

    // Backpressure: three stalled cycles hold the r1 result.
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_r0_ready", r0_ready, 0);
      check("bp_r1_ready", r1_ready, 0);
      tick();
      check("bp_valid", res_valid, 1);
      check("bp_id",    res_id,    1);
      check("bp_op",    res_op,    2'b01);
      check("bp_data",  res_data,  P_OR);
    end

    // Release: the requester not last granted (r0) wins.
    res_ready = 1'b1;
    #1;
    check("bp_rel_r0_ready", r0_ready, 1);
    check("bp_rel_r1_ready", r1_ready, 0);
    tick();
    check("bp_rel_id",   res_id,   0);
    check("bp_rel_data", res_data, P_AND);

    // Sole requester r1 with NOT; b is ignored.
    r0_valid = 1'b0;
    r1_op = 2'b11; r1_a = P_NA; r1_b = {$urandom, $urandom};
    #1;
    check("not_r1_ready", r1_ready, 1);
    tick();
    check("not_valid", res_valid, 1);
    check("not_id",    res_id,    1);
    check("not_op",    res_op,    2'b11);
    check("not_data",  res_data,  P_NOT);

    // Following contention goes to r0.
    r0_valid = 1'b1;
    r1_op = 2'b01; r1_a = P_F0; r1_b = P_FF00;
    #1;
    check("after_not_r0_ready", r0_ready, 1);
    check("after_not_r1_ready", r1_ready, 0);
    tick();
    check("after_not_id",   res_id,   0);
    check("after_not_data", res_data, P_AND);

    // Stall while full, then reset: result discarded, r0 priority restored
    // (without the reset r1 would win, since r0 was granted last).
    res_ready = 1'b0;
    tick();
    check("pre_rst_valid", res_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_r0_ready", r0_ready, 0);
    check("mid_rst_r1_ready", r1_ready, 0);
    tick();
    check("mid_rst_valid", res_valid, 0);
    rst_n = 1'b1;
    res_ready = 1'b1;
    #1;
    check("post_rst_r0_ready", r0_ready, 1);
    check("post_rst_r1_ready", r1_ready, 0);
    tick();
    check("post_rst_valid", res_valid, 1);
    check("post_rst_id",    res_id,    0);
    check("post_rst_data",  res_data,  P_AND);

    r0_valid = 1'b0;
    r1_valid = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
